// File: rtl/reg_file.sv
// Architectural register file with rename-status (busy/tag) tracking for the Tomasulo core.
// Two combinational source queries with commit bypass; issue renames, commit retires, rollback flushes.
module reg_file #(
    parameter int ROB_BITS = 4,
    parameter int DATA_W   = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic [REG_BITS-1:0] reg_rs1,
    output logic                reg_rs1_rdy,
    output logic [DATA_W-1:0]   reg_rs1_val,
    output logic [ROB_BITS-1:0] reg_rs1_rob_pos,
    input  logic [REG_BITS-1:0] reg_rs2,
    output logic                reg_rs2_rdy,
    output logic [DATA_W-1:0]   reg_rs2_val,
    output logic [ROB_BITS-1:0] reg_rs2_rob_pos,
    input  logic                issue,
    input  logic [REG_BITS-1:0] issue_rd,
    input  logic [ROB_BITS-1:0] issue_rob_pos,
    input  logic                commit,
    input  logic [REG_BITS-1:0] commit_rd,
    input  logic [DATA_W-1:0]   commit_val,
    input  logic [ROB_BITS-1:0] commit_rob_pos
);
    localparam int NREG = 1 << REG_BITS;

    logic [DATA_W-1:0]   val_reg  [NREG];
    logic                busy_reg [NREG];
    logic [ROB_BITS-1:0] tag_reg  [NREG];

    typedef struct packed {
        logic                rdy;
        logic [DATA_W-1:0]   val;
        logic [ROB_BITS-1:0] pos;
    } query_t;

    // Queries see pre-edge state; a same-cycle issue is deliberately ignored here.
    function automatic query_t lookup(input logic [REG_BITS-1:0] r);
        query_t q;
        q.rdy = 1'b1;
        q.val = '0;
        q.pos = '0;
        if (rst || r == '0) begin
            q.rdy = 1'b1;
        end else if (!busy_reg[r]) begin
            q.val = val_reg[r];
        end else if (commit && commit_rd == r && commit_rob_pos == tag_reg[r]) begin
            q.val = commit_val;
        end else begin
            q.rdy = 1'b0;
            q.pos = tag_reg[r];
        end
        return q;
    endfunction

    query_t q1, q2;

    always_comb begin
        q1 = lookup(reg_rs1);
        q2 = lookup(reg_rs2);
    end

    assign reg_rs1_rdy     = q1.rdy;
    assign reg_rs1_val     = q1.val;
    assign reg_rs1_rob_pos = q1.pos;
    assign reg_rs2_rdy     = q2.rdy;
    assign reg_rs2_val     = q2.val;
    assign reg_rs2_rob_pos = q2.pos;

    // Register 0 is only ever touched by reset, so it stays zero and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                val_reg[i]  <= '0;
                busy_reg[i] <= 1'b0;
                tag_reg[i]  <= '0;
            end
        end else if (rdy) begin
            for (int i = 1; i < NREG; i++) begin
                if (commit && commit_rd == REG_BITS'(i))
                    val_reg[i] <= commit_val;
                if (rollback) begin
                    busy_reg[i] <= 1'b0;
                end else if (issue && issue_rd == REG_BITS'(i)) begin
                    busy_reg[i] <= 1'b1;
                    tag_reg[i]  <= issue_rob_pos;
                end else if (commit && commit_rd == REG_BITS'(i) &&
                             busy_reg[i] && tag_reg[i] == commit_rob_pos) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: walks rename, bypass, rollback, freeze and x0 scenarios step by step.
module tb_reg_file;
    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic [4:0]  reg_rs1, reg_rs2;
    logic        reg_rs1_rdy, reg_rs2_rdy;
    logic [31:0] reg_rs1_val, reg_rs2_val;
    logic [3:0]  reg_rs1_rob_pos, reg_rs2_rob_pos;
    logic        issue, commit;
    logic [4:0]  issue_rd, commit_rd;
    logic [3:0]  issue_rob_pos, commit_rob_pos;
    logic [31:0] commit_val;

    int total = 0;
    int bad   = 0;

    reg_file #(.ROB_BITS(4), .DATA_W(32), .REG_BITS(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .reg_rs1(reg_rs1), .reg_rs1_rdy(reg_rs1_rdy), .reg_rs1_val(reg_rs1_val),
        .reg_rs1_rob_pos(reg_rs1_rob_pos),
        .reg_rs2(reg_rs2), .reg_rs2_rdy(reg_rs2_rdy), .reg_rs2_val(reg_rs2_val),
        .reg_rs2_rob_pos(reg_rs2_rob_pos),
        .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
        .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_pos(commit_rob_pos)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic r, input logic [31:0] v, input logic [3:0] p);
        cmp({name, ".rs1_rdy"}, 32'(reg_rs1_rdy), 32'(r));
        cmp({name, ".rs1_val"}, reg_rs1_val, v);
        cmp({name, ".rs1_pos"}, 32'(reg_rs1_rob_pos), 32'(p));
        $display("check %s rs1=%0d rdy=%0b val=%h pos=%0d", name, reg_rs1, reg_rs1_rdy, reg_rs1_val, reg_rs1_rob_pos);
    endtask

    task automatic chk2(input string name, input logic r, input logic [31:0] v, input logic [3:0] p);
        cmp({name, ".rs2_rdy"}, 32'(reg_rs2_rdy), 32'(r));
        cmp({name, ".rs2_val"}, reg_rs2_val, v);
        cmp({name, ".rs2_pos"}, 32'(reg_rs2_rob_pos), 32'(p));
        $display("check %s rs2=%0d rdy=%0b val=%h pos=%0d", name, reg_rs2, reg_rs2_rdy, reg_rs2_val, reg_rs2_rob_pos);
    endtask

    task automatic idle();
        rollback = 0; issue = 0; issue_rd = 0; issue_rob_pos = 0;
        commit = 0; commit_rd = 0; commit_val = 0; commit_rob_pos = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] t);
        issue = 1; issue_rd = rd; issue_rob_pos = t;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
        commit = 1; commit_rd = rd; commit_rob_pos = t; commit_val = v;
    endtask

    initial begin
        rst = 1; rdy = 1; reg_rs1 = 5; reg_rs2 = 0;
        idle();
        @(negedge clk);
        #1 chk1("in_reset", 1, 32'h0, 0);
        step(); step();
        rst = 0;

        // Post-reset queries
        reg_rs1 = 5; reg_rs2 = 0;
        #1 chk1("reset_r5", 1, 32'h0, 0);
        chk2("reset_r0", 1, 32'h0, 0);

        // Rename then commit with bypass
        do_issue(3, 7); step(); idle();
        reg_rs1 = 3;
        #1 chk1("busy_r3", 0, 32'h0, 7);
        do_commit(3, 7, 32'hDEADBEEF);
        #1 chk1("bypass_r3", 1, 32'hDEADBEEF, 0);
        step(); idle();
        #1 chk1("retired_r3", 1, 32'hDEADBEEF, 0);

        // Older commit must not retire a younger rename
        do_issue(4, 2); step();
        do_issue(4, 5); step(); idle();
        reg_rs1 = 4;
        do_commit(4, 2, 32'h11);
        #1 chk1("stale_commit_r4", 0, 32'h0, 5);
        step(); idle();
        #1 chk1("still_busy_r4", 0, 32'h0, 5);
        do_commit(4, 5, 32'h22);
        #1 chk1("bypass_r4", 1, 32'h22, 0);
        step(); idle();
        #1 chk1("retired_r4", 1, 32'h22, 0);

        // Same-cycle commit and re-issue: issue wins busy/tag
        do_issue(6, 1); step(); idle();
        reg_rs1 = 6;
        do_commit(6, 1, 32'h33); do_issue(6, 9);
        #1 chk1("bypass_r6", 1, 32'h33, 0);
        step(); idle();
        #1 chk1("reissued_r6", 0, 32'h0, 9);

        // Non-busy commit writes value only
        do_commit(8, 0, 32'h88); step(); idle();
        reg_rs1 = 8;
        #1 chk1("plain_write_r8", 1, 32'h88, 0);

        // Rollback flushes busy, drops issue, keeps commit value
        do_issue(8, 3); step();
        do_issue(9, 4); step(); idle();
        reg_rs1 = 8; reg_rs2 = 9;
        #1 chk1("busy_r8", 0, 32'h0, 3);
        chk2("busy_r9", 0, 32'h0, 4);
        rollback = 1; do_issue(10, 6); do_commit(9, 0, 32'h99);
        step(); idle();
        #1 chk1("rolled_r8", 1, 32'h88, 0);
        chk2("rolled_r9", 1, 32'h99, 0);
        reg_rs1 = 10; reg_rs2 = 6;
        #1 chk1("rolled_r10", 1, 32'h0, 0);
        chk2("rolled_r6", 1, 32'h33, 0);

        // rdy=0 freezes all state
        do_issue(14, 2); step(); idle();
        rdy = 0;
        do_issue(12, 1); step(); idle();
        do_commit(13, 0, 32'h55); step(); idle();
        do_commit(14, 2, 32'h77); step(); idle();
        rdy = 1;
        reg_rs1 = 12; reg_rs2 = 13;
        #1 chk1("frozen_r12", 1, 32'h0, 0);
        chk2("frozen_r13", 1, 32'h0, 0);
        reg_rs1 = 14;
        #1 chk1("frozen_r14", 0, 32'h0, 2);

        // x0 is immutable
        reg_rs1 = 0;
        do_issue(0, 5); do_commit(0, 5, 32'hFF);
        #1 chk1("x0_during", 1, 32'h0, 0);
        step(); idle();
        #1 chk1("x0_after", 1, 32'h0, 0);

        // Mid-run reset clears everything and forces outputs
        reg_rs1 = 14; reg_rs2 = 4;
        rst = 1;
        #1 chk1("force_r14", 1, 32'h0, 0);
        step(); rst = 0;
        #1 chk1("reset_r14", 1, 32'h0, 0);
        chk2("reset_r4", 1, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file plus rename-status table for the Tomasulo core; answers the decoder's two source-operand queries and tracks the ROB tag producing each register.
- Responder end of the decoder's RegFile query interface.
- Issue path marks a destination register busy with its ROB tag.
- ROB commit path writes values back and clears busy status.
- Rollback flushes all rename status.

Parameters:
- ROB_BITS, 4, width of ROB tag (ROB holds 2^ROB_BITS entries)
- DATA_W, 32, register data width
- REG_BITS, 5, register index width (32 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low, no state changes
- rollback  in  1  misprediction flush from ROB
- reg_rs1  in  REG_BITS  query index, source 1
- reg_rs1_rdy  out  1  source 1 value available
- reg_rs1_val  out  DATA_W  source 1 value (valid when rdy=1, else 0)
- reg_rs1_rob_pos  out  ROB_BITS  producing ROB tag (valid when rdy=0, else 0)
- reg_rs2  in  REG_BITS  query index, source 2
- reg_rs2_rdy  out  1  as rs1
- reg_rs2_val  out  DATA_W  as rs1
- reg_rs2_rob_pos  out  ROB_BITS  as rs1
- issue  in  1  decoder issues an instruction this cycle
- issue_rd  in  REG_BITS  destination of issued instruction (0 = none)
- issue_rob_pos  in  ROB_BITS  ROB tag allocated to issued instruction
- commit  in  1  ROB commits a register-writing instruction this cycle
- commit_rd  in  REG_BITS  committed destination
- commit_val  in  DATA_W  committed value
- commit_rob_pos  in  ROB_BITS  ROB tag of committing entry

Behaviour:
- State: val[0..31] (DATA_W), busy[0..31] (1 bit), tag[0..31] (ROB_BITS).
- Reset (rst=1 at edge): all val=0, busy=0, tag=0.
- While rst=1, all query outputs forced to rdy=1, val=0, rob_pos=0.
- Query outputs are combinational, zero latency, and read pre-edge state. Per source with index r:
  - r==0: rdy=1, val=0, pos=0.
  - busy[r]=0: rdy=1, val=val[r], pos=0.
  - busy[r]=1 and commit && commit_rd==r && commit_rob_pos==tag[r] (same-cycle bypass): rdy=1, val=commit_val, pos=0.
  - otherwise: rdy=0, val=0, pos=tag[r].
- A same-cycle issue never affects the query result; sources see state before their own rd is renamed.
- Sequential updates apply only when rdy=1 and rst=0. rdy=0 freezes all state; query outputs still reflect held state.
- Commit (commit=1, commit_rd!=0):
  - val[commit_rd] <= commit_val.
  - busy[commit_rd] <= 0 only if busy was set and tag[commit_rd]==commit_rob_pos, and no same-cycle issue to the same rd.
  - On tag mismatch (a younger writer is pending), only the value is written; busy and tag are unchanged.
- Issue (issue=1, issue_rd!=0, rollback=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_pos.
- Issue and commit to the same rd in one cycle: the value is written, and issue wins on busy/tag (busy=1, tag=issue_rob_pos).
- Rollback=1:
  - All busy <= 0 and issue is ignored.
  - A commit in the same cycle still writes its value.
  - Tags need not be cleared.
- Register 0 is never written and never busy, whatever the inputs.
- Tag wrap-around needs no special handling: the ROB guarantees no two in-flight entries share a tag.

Test Plan:
- Reset, then query rs1=5, rs2=0 -> both rdy=1, val=0, pos=0.
- Issue rd=3 tag=7; next cycle query rs1=3 -> rdy=0, pos=7. Then commit rd=3 tag=7 val=0xDEADBEEF -> same-cycle bypass rdy=1, val=0xDEADBEEF; next cycle busy cleared, val=0xDEADBEEF.
- Issue rd=4 tag=2, then issue rd=4 tag=5, then commit rd=4 tag=2 val=0x11 -> val[4]=0x11 but query still rdy=0, pos=5. Commit tag=5 val=0x22 -> rdy=1, val=0x22.
- Same cycle: commit rd=6 tag=1 val=0x33 and issue rd=6 tag=9 (busy[6] tag 1 beforehand) -> query that cycle gives bypass rdy=1, val=0x33; next cycle rdy=0, pos=9.
- Issue rd=8 tag=3 and rd=9 tag=4; assert rollback together with issue rd=10 tag=6 -> next cycle regs 8, 9, 10 all report rdy=1 with old values.
- rdy=0 with issue rd=12 tag=1 and commit rd=13 val=0x55 -> no state change. Issue or commit to rd=0 -> x0 remains rdy=1, val=0.
